// File: rtl/phys_ram_pkg.sv
// phys_ram_pkg: shared types, defaults and counter helper for the physical RAM responder
package phys_ram_pkg;
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam int DEFAULT_DEPTH_WORDS = 1024;
  localparam logic [31:0] DEFAULT_OOR_DATA = 32'hDEADBEEF;
  localparam int CNT_W = 16;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/phys_ram_responder_if.sv
// phys_ram_responder_if: memory-controller, loader and status signals of the RAM responder
interface phys_ram_responder_if;
  import phys_ram_pkg::*;
  logic phRequest;
  logic phWriteEnable;
  logic [31:0] phRamAddress;
  logic [31:0] phRamOut;
  logic [31:0] phRamIn;
  logic ldRequest;
  logic [31:0] ldAddress;
  logic [31:0] ldData;
  logic ldReady;
  logic [CNT_W-1:0] oorCount;
  logic [CNT_W-1:0] collisionCount;
  modport master (
    output phRequest, phWriteEnable, phRamAddress, phRamOut, ldRequest, ldAddress, ldData,
    input  phRamIn, ldReady, oorCount, collisionCount
  );
  modport slave (
    input  phRequest, phWriteEnable, phRamAddress, phRamOut, ldRequest, ldAddress, ldData,
    output phRamIn, ldReady, oorCount, collisionCount
  );
endinterface

// File: rtl/ram_array.sv
// ram_array: DEPTH x 32 storage with one synchronous write port and one asynchronous read port
module ram_array #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/phys_ram_responder.sv
// phys_ram_responder: two-state word RAM responder for a memory controller with a background loader port
module phys_ram_responder
  import phys_ram_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter logic [31:0] OOR_DATA = DEFAULT_OOR_DATA
) (
  input logic clk,
  input logic reset,
  phys_ram_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state;
  logic lat_we;
  logic [29:0] lat_idx;
  logic [31:0] lat_data;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic [AW-1:0] waddr;
  logic lat_in, ld_in, ctrl_wr, ram_we;
  logic unused_lsbs;
  function automatic logic in_range(input logic [29:0] idx);
    return {2'b00, idx} < 32'(DEPTH_WORDS);
  endfunction
  assign unused_lsbs = ^{bus.phRamAddress[1:0], bus.ldAddress[1:0]};
  assign lat_in = in_range(lat_idx);
  assign ld_in = in_range(bus.ldAddress[31:2]);
  assign bus.ldReady = state == IDLE && !bus.phRequest;
  // The single write port is shared; the loader only gets it when the controller is not using the array.
  assign ctrl_wr = state == ACCESS && lat_we && lat_in;
  assign ram_we = !reset && (ctrl_wr || (bus.ldRequest && bus.ldReady && ld_in));
  assign waddr = ctrl_wr ? lat_idx[AW-1:0] : bus.ldAddress[AW+1:2];
  assign wdata = ctrl_wr ? lat_data : bus.ldData;
  ram_array #(.DEPTH(DEPTH_WORDS)) u_ram (
    .clk(clk),
    .we(ram_we),
    .waddr(waddr),
    .raddr(lat_idx[AW-1:0]),
    .wdata(wdata),
    .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.phRamIn <= '0;
      bus.oorCount <= '0;
      bus.collisionCount <= '0;
    end else if (state == IDLE) begin
      if (bus.phRequest) begin
        state <= ACCESS;
        lat_we <= bus.phWriteEnable;
        lat_idx <= bus.phRamAddress[31:2];
        lat_data <= bus.phRamOut;
      end
    end else begin
      state <= IDLE;
      if (bus.phRequest) bus.collisionCount <= sat_inc(bus.collisionCount);
      if (!lat_in) bus.oorCount <= sat_inc(bus.oorCount);
      if (!lat_we) bus.phRamIn <= lat_in ? rdata : OOR_DATA;
    end
  end
endmodule

// File: tb/tb_phys_ram_responder.sv
// tb_phys_ram_responder: randomized scoreboard bench with a word-array reference model
module tb_phys_ram_responder;
  localparam int DEPTH = 1024;
  localparam logic [31:0] OOR = 32'hDEADBEEF;
  typedef struct {int cyc; int kind; logic [31:0] val;} exp_t;
  logic clk = 0;
  logic reset = 1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  logic [31:0] m [int];
  int oor_m = 0;
  int col_m = 0;
  logic [31:0] last_rd = '0;
  string kname [4] = '{"phRamIn", "oorCount", "collisionCount", "ldReady"};

  phys_ram_responder_if bus();
  phys_ram_responder dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int c, int k, logic [31:0] v);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = sb[i].kind == 0 ? bus.phRamIn :
              sb[i].kind == 1 ? 32'(bus.oorCount) :
              sb[i].kind == 2 ? 32'(bus.collisionCount) : 32'(bus.ldReady);
        checks++;
        if (act !== sb[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", kname[sb[i].kind], cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  function automatic logic in_rng(logic [31:0] a);
    return a[31:2] < 30'(DEPTH);
  endfunction

  function automatic logic [31:0] rnd_addr();
    int i;
    i = $urandom_range(0, 67);
    i = i < 64 ? i : 1020 + (i - 64);
    return {30'(i), 2'($urandom_range(0, 3))};
  endfunction

  function automatic logic [31:0] oor_addr();
    return $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF :
           {30'(DEPTH + $urandom_range(0, 100000)), 2'($urandom_range(0, 3))};
  endfunction

  task automatic ld(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.ldRequest = 1; bus.ldAddress = a; bus.ldData = d;
    push(cyc, 3, 1);
    if (in_rng(a)) m[int'(a[31:2])] = d;
    @(posedge clk); #1;
    bus.ldRequest = 0;
  endtask

  task automatic ctrl(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic col, input logic ld_try, input logic [31:0] ld_a);
    int k;
    logic inr;
    @(posedge clk); #1;
    k = cyc;
    bus.phRequest = 1; bus.phWriteEnable = we; bus.phRamAddress = a; bus.phRamOut = d;
    inr = in_rng(a);
    if (!we) begin
      last_rd = inr ? m[int'(a[31:2])] : OOR;
      push(k + 2, 0, last_rd);
      push(k + 3, 0, last_rd);
    end else begin
      if (inr) m[int'(a[31:2])] = d;
      push(k + 2, 0, last_rd);
    end
    if (!inr && oor_m < 65535) oor_m++;
    if (col && col_m < 65535) col_m++;
    push(k + 2, 1, 32'(oor_m));
    push(k + 2, 2, 32'(col_m));
    @(posedge clk); #1;
    if (!col) bus.phRequest = 0;
    if (ld_try) begin
      bus.ldRequest = 1; bus.ldAddress = ld_a; bus.ldData = $urandom;
      push(k + 1, 3, 0);
    end
    if (col || ld_try) begin
      @(posedge clk); #1;
      bus.phRequest = 0; bus.ldRequest = 0;
    end
  endtask

  initial begin
    logic [31:0] a;
    int r;
    bus.phRequest = 0; bus.phWriteEnable = 0; bus.phRamAddress = '0; bus.phRamOut = '0;
    bus.ldRequest = 0; bus.ldAddress = '0; bus.ldData = '0;
    repeat (3) @(posedge clk);
    #1;
    push(cyc, 0, 0); push(cyc, 1, 0); push(cyc, 2, 0); push(cyc, 3, 1);
    reset = 0;
    for (int i = 0; i < 64; i++) ld({30'(i), 2'($urandom_range(0, 3))}, $urandom);
    for (int i = 1020; i < 1024; i++) ld({30'(i), 2'b00}, $urandom);
    ld(32'h40, 32'h12345678);
    ctrl(0, 32'h40, 0, 0, 0, 0);
    ctrl(1, 32'h104, 32'hCAFEF00D, 0, 0, 0);
    ctrl(0, 32'h107, 0, 0, 0, 0);
    ctrl(0, 32'h1000, 0, 0, 0, 0);
    ctrl(1, 32'h1000, 32'h0BADF00D, 0, 0, 0);
    ctrl(0, 32'h0, 0, 0, 0, 0);
    ctrl(0, 32'h40, 0, 1, 1, 32'h44);
    ctrl(0, 32'h44, 0, 0, 0, 0);
    ctrl(0, 32'h200 >> 0 & 32'h0FC, 0, 0, 0, 0);
    ctrl(0, 32'h200, 0, 0, 0, 0);
    ctrl(0, 32'h204, 0, 0, 0, 0);
    ctrl(0, {30'd1023, 2'b11}, 0, 0, 0, 0);
    for (int i = 0; i < 90; i++) begin
      r = $urandom_range(0, 9);
      a = rnd_addr();
      if (r < 2) ld(a, $urandom);
      else if (r < 5) ctrl(0, a, 0, 0, 0, 0);
      else if (r < 7) ctrl(1, a, $urandom, 0, 0, 0);
      else if (r == 7) ctrl(1'($urandom_range(0, 1)), oor_addr(), $urandom, 0, 0, 0);
      else if (r == 8) ctrl(0, a, 0, 1, 0, 0);
      else ctrl(1'($urandom_range(0, 1)), a, $urandom, 0, 1, rnd_addr());
    end
    ld(32'h80, 32'hA5A5_0080);
    @(posedge clk); #1;
    r = cyc;
    bus.phRequest = 1; bus.phWriteEnable = 1; bus.phRamAddress = 32'h80; bus.phRamOut = 32'h1111_2222;
    @(posedge clk); #1;
    bus.phRequest = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    oor_m = 0; col_m = 0; last_rd = '0;
    push(r + 2, 0, 0); push(r + 2, 1, 0); push(r + 2, 2, 0);
    ctrl(0, 32'h80, 0, 0, 0, 0);
    ctrl(0, 32'h44, 0, 0, 0, 0);
    ctrl(0, {30'd1021, 2'b00}, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.phRamIn !== last_rd) begin
      failures++;
      $display("FAIL final phRamIn got=%h exp=%h", bus.phRamIn, last_rd);
    end
    checks++;
    if (bus.oorCount !== 16'(oor_m)) begin
      failures++;
      $display("FAIL final oorCount got=%h exp=%h", bus.oorCount, oor_m);
    end
    checks++;
    if (bus.collisionCount !== 16'(col_m)) begin
      failures++;
      $display("FAIL final collisionCount got=%h exp=%h", bus.collisionCount, col_m);
    end
    checks++;
    if (bus.ldReady !== 1'b1) begin
      failures++;
      $display("FAIL final ldReady got=%b", bus.ldReady);
    end
    foreach (sb[i]) begin
      checks++;
      failures++;
      $display("FAIL stale_%s due=%0d exp=%h", kname[sb[i].kind], sb[i].cyc, sb[i].val);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/phys_ram_responder.md
PHYS_RAM_RESPONDER -- requirements
Module: phys_ram_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter OOR_DATA, default 32'hDEADBEEF, meaning read data returned for out-of-range addresses.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port phRequest  input  1  access request, sampled each edge.
REQ-006 SHALL have port phWriteEnable  input  1  1 = write, 0 = read; qualified by phRequest.
REQ-007 SHALL have port phRamAddress  input  32  byte address.
REQ-008 SHALL have port phRamOut  input  32  write data from the memory controller.
REQ-009 SHALL have port phRamIn  output  32  registered read data to the memory controller.
REQ-010 SHALL have port ldRequest  input  1  loader write strobe (image preload/test).
REQ-011 SHALL have port ldAddress  input  32  loader byte address.
REQ-012 SHALL have port ldData  input  32  loader write data.
REQ-013 SHALL have port ldReady  output  1  loader write accepted this cycle when high.
REQ-014 SHALL have port oorCount  output  16  saturating count of out-of-range controller accesses.
REQ-015 SHALL have port collisionCount  output  16  saturating count of controller requests dropped while busy.

Function
REQ-016 SHALL implement states IDLE and ACCESS.
REQ-017 IDLE with phRequest=1 at edge E0: latch address, write-enable, write data; go to ACCESS.
REQ-018 ACCESS at edge E1: perform the latched access; return to IDLE unconditionally.
REQ-019 Read: phRamIn <= mem[addr[31:2]] at E1, so data is stable at E2 (controller samples two edges after request); phRamIn held until the next read completes.
REQ-020 Write: mem[addr[31:2]] <= data at E1; phRamIn unchanged.
REQ-021 addr[1:0] ignored; word index = addr[31:2].
REQ-022 Out of range (addr[31:2] >= DEPTH_WORDS): read returns OOR_DATA, write dropped, oorCount +1 (saturate at 16'hFFFF).
REQ-023 phRequest=1 while in ACCESS: request dropped, collisionCount +1 (saturating); no state change.
REQ-024 Back-to-back requests separated by one or more idle cycles (two-word page-table fetch pattern) SHALL each be served with identical E0->E2 timing.
REQ-025 ldReady = (state==IDLE) && !phRequest (combinational); controller always has priority.
REQ-026 ldRequest && ldReady: mem[ldAddress[31:2]] <= ldData at that edge; out-of-range loader writes dropped silently (no count).
REQ-027 ldRequest while ldReady=0: ignored; loader retries.
REQ-028 Read of a word in the same E1 it is written SHALL not occur (single access per ACCESS); loader write at E0 followed by controller read returns the new data.

Reset
REQ-029 reset=1 at an edge: state <= IDLE, phRamIn <= 0, oorCount <= 0, collisionCount <= 0.
REQ-030 Reset SHALL NOT clear memory contents.
REQ-031 Reset during ACCESS: pending access abandoned (write not performed, phRamIn = 0).
REQ-032 reset has priority over phRequest and ldRequest on the same edge.

Structure
REQ-033 Package phys_ram_pkg SHALL hold the state enum, DEFAULT_DEPTH_WORDS, DEFAULT_OOR_DATA and the counter width.
REQ-034 Storage SHALL be a sub-module ram_array (one synchronous write port, one read port, DEPTH_WORDS x 32); FSM, range check and counters stay in phys_ram_responder.

Verification
REQ-035 Loader writes 32'h12345678 to 0x40; controller read of 0x40 pulsed at E0 -> phRamIn = 32'h12345678 at E1, held through E2.
REQ-036 Controller write 32'hCAFEF00D to 0x104, then read of 0x107 -> phRamIn = 32'hCAFEF00D (low bits ignored).
REQ-037 Read of 0x1000 with DEPTH_WORDS=1024 -> phRamIn = 32'hDEADBEEF, oorCount = 1; write there -> memory unchanged, oorCount = 2.
REQ-038 phRequest held high two cycles -> one access, collisionCount = 1; ldRequest during ACCESS -> ldReady = 0, no write.
REQ-039 Page-table fetch pattern: reads at 0x200 and 0x204 with one idle cycle between -> both words returned, each two edges after its request.
REQ-040 Reset asserted in ACCESS of a write to 0x80 -> mem[0x80] unchanged, phRamIn = 0, counters 0, preloaded words retained.
